// File: rtl/updown_cmd_ctrl.sv
// Button command stage for the up/down counter.
// Sync, debounce and edge-detect four buttons; drive enable/ctrl/cnt_rst.
module updown_cmd_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RST_PULSE       = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_stop,
  input  logic btn_clr,
  input  logic overflow,
  output logic enable,
  output logic ctrl,
  output logic cnt_rst,
  output logic halted
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCW = $clog2(RST_PULSE + 1);

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    HALT,
    CLEAR
  } state_t;

  logic [3:0]    btn;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    lvl;
  logic [3:0]    lvl_d;
  logic [3:0]    prs;
  logic [CW-1:0] db_cnt [4];

  state_t         st;
  state_t         ns;
  logic [PCW-1:0] pcnt;
  logic [PCW-1:0] pcnt_n;

  logic en_n;
  logic ctrl_n;
  logic rst_n;
  logic halt_n;

  logic p_up;
  logic p_down;
  logic p_stop;
  logic p_clr;

  assign btn    = {btn_clr, btn_stop, btn_down, btn_up};
  assign p_up   = prs[0];
  assign p_down = prs[1];
  assign p_stop = prs[2];
  assign p_clr  = prs[3];

  // Press pulse is registered so state follows E0+DEBOUNCE_CYCLES+3.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      prs   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      prs   <= lvl & ~lvl_d;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i]    <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= IDLE;
      pcnt    <= '0;
      enable  <= 1'b0;
      ctrl    <= 1'b0;
      cnt_rst <= 1'b0;
      halted  <= 1'b0;
    end else begin
      st      <= ns;
      pcnt    <= pcnt_n;
      enable  <= en_n;
      ctrl    <= ctrl_n;
      cnt_rst <= rst_n;
      halted  <= halt_n;
    end
  end

  always_comb begin
    ns     = st;
    pcnt_n = pcnt;
    unique case (st)
      CLEAR: begin
        if (pcnt == PCW'(RST_PULSE)) begin
          ns     = IDLE;
          pcnt_n = '0;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      HALT: begin
        if (p_clr) begin
          ns     = CLEAR;
          pcnt_n = '0;
        end
      end
      IDLE, UP, DOWN: begin
        if (p_clr) begin
          ns     = CLEAR;
          pcnt_n = '0;
        end else if (overflow) begin
          ns = HALT;
        end else if (p_stop && st != IDLE) begin
          ns = IDLE;
        end else if (p_up && p_down) begin
          ns = st;
        end else if (p_up && st != UP) begin
          ns = UP;
        end else if (p_down && st != DOWN) begin
          ns = DOWN;
        end
      end
      default: begin
        ns     = IDLE;
        pcnt_n = '0;
      end
    endcase
  end

  always_comb begin
    en_n   = (ns == UP) || (ns == DOWN);
    ctrl_n = (ns == UP);
    rst_n  = (ns == CLEAR) && (pcnt_n < PCW'(RST_PULSE));
    halt_n = (ns == HALT);
  end

endmodule

// File: tb/tb_updown_cmd_ctrl.sv
// Scoreboard bench for updown_cmd_ctrl.
// Expected {enable,ctrl,cnt_rst,halted} queued with a due cycle.
module tb_updown_cmd_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_clr = 1'b0;
  logic overflow = 1'b0;
  logic enable;
  logic ctrl;
  logic cnt_rst;
  logic halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int       due;
    logic [3:0] exp;
    string    tag;
  } sb_t;

  sb_t sb[$];

  updown_cmd_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RST_PULSE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_stop(btn_stop),
    .btn_clr(btn_clr),
    .overflow(overflow),
    .enable(enable),
    .ctrl(ctrl),
    .cnt_rst(cnt_rst),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc,
               got[3:0], exp[3:0]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, int'({enable, ctrl, cnt_rst, halted}),
            int'(sb[i].exp));
        sb.delete(i);
      end
    end
  end

  task automatic push(input string tag, input int dl,
                      input logic [3:0] exp);
    sb_t e;
    e.due = cyc + dl;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    push("rst", 0, 4'b0000);
    reset = 1'b1;
    tick(2);
    push("idle_hold", 0, 4'b0000);

    btn_up = 1'b1;
    push("up_pre", 7, 4'b0000);
    push("up_lat", 8, 4'b1100);
    tick(10);
    btn_up = 1'b0;
    tick(8);
    btn_down = 1'b1;
    tick(3);
    btn_down = 1'b0;
    push("glitch", 8, 4'b1100);
    tick(10);

    btn_down = 1'b1;
    push("rev_pre", 7, 4'b1100);
    push("rev_dn", 8, 4'b1000);
    tick(10);
    btn_down = 1'b0;
    tick(8);
    btn_stop = 1'b1;
    push("stop", 8, 4'b0000);
    tick(10);
    btn_stop = 1'b0;
    tick(8);

    btn_up = 1'b1;
    push("up2", 8, 4'b1100);
    tick(10);
    btn_up = 1'b0;
    tick(8);
    overflow = 1'b1;
    push("ovf_pre", 0, 4'b1100);
    push("halt", 1, 4'b0001);
    tick(2);
    btn_up = 1'b1;
    push("halt_up", 8, 4'b0001);
    tick(10);
    btn_up = 1'b0;
    tick(8);
    btn_down = 1'b1;
    push("halt_dn", 8, 4'b0001);
    tick(10);
    btn_down = 1'b0;
    tick(8);
    btn_clr = 1'b1;
    push("clr_pre", 7, 4'b0001);
    push("clr_p0", 8, 4'b0010);
    push("clr_p1", 9, 4'b0010);
    push("clr_settle", 10, 4'b0000);
    push("clr_idle", 11, 4'b0000);
    push("idle_ovf", 12, 4'b0001);
    tick(12);
    overflow = 1'b0;
    btn_clr = 1'b0;
    tick(8);
    btn_clr = 1'b1;
    push("clr2_p0", 8, 4'b0010);
    push("clr2_set", 10, 4'b0000);
    push("clr2_idle", 12, 4'b0000);
    tick(12);
    btn_clr = 1'b0;
    tick(8);

    btn_up = 1'b1;
    btn_down = 1'b1;
    push("both_a", 8, 4'b0000);
    push("both_b", 10, 4'b0000);
    tick(12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(8);
    btn_up = 1'b1;
    push("up3", 8, 4'b1100);
    tick(10);
    btn_up = 1'b0;
    tick(8);
    btn_clr = 1'b1;
    btn_stop = 1'b1;
    push("clrstop", 8, 4'b0010);
    push("clrstop_e", 11, 4'b0000);
    tick(12);
    btn_clr = 1'b0;
    btn_stop = 1'b0;
    tick(8);

    btn_down = 1'b1;
    push("down", 8, 4'b1000);
    tick(10);
    btn_down = 1'b0;
    tick(8);
    btn_up = 1'b1;
    reset = 1'b0;
    push("mid_rst", 1, 4'b0000);
    tick(1);
    reset = 1'b1;
    push("rel_pre", 7, 4'b0000);
    push("rel_up", 8, 4'b1100);
    tick(10);
    btn_up = 1'b0;
    tick(3);

    if (sb.size() != 0) chk("leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
